v_alu_div_unit: RTL and testbench

//  Iterative radix-2 divide/remainder unit for one vector lane; consumes the
//  5-bit vector ALU op code (divu_op, divs_op, remu_op, rems_op) issued to the lane.

---
 rtl/v_alu_div_unit.sv | 192 +++++++++++++++++++
 tb/tb_v_alu_div_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v_alu_div_unit.sv
// Iterative radix-2 restoring divide/remainder unit for one vector lane.
// Optional macro V_DIV_FAST_PATH_EN: zero divisor, signed overflow and |a|<|b| skip CALC.
module v_alu_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [4:0]            alu_op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  illegal_op_o
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
    localparam logic [W-1:0]  MIN_NEG   = {1'b1, {(W-1){1'b0}}};

    localparam logic [4:0] OP_DIVU = 5'b01101;
    localparam logic [4:0] OP_DIVS = 5'b01110;
    localparam logic [4:0] OP_REMU = 5'b01111;
    localparam logic [4:0] OP_REMS = 5'b10000;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e          state_q, state_d;
    logic            en_q, en_d;
    logic            is_div_q, is_div_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            bzero_q, bzero_d;
    logic            ovf_q, ovf_d;
    logic [W-1:0]    a_raw_q, a_raw_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [W-1:0]    res_q, res_d;
    logic            illegal_q, illegal_d;

    logic            accept, legal, op_signed, op_div;
    logic            a_neg, b_neg, b_zero, sgn_ovf;
    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      part;
    logic            ge;
    logic [W-1:0]    q_fix, r_fix, final_res;

    assign ready_o      = en_q && (state_q == S_IDLE) && !flush_i;
    assign valid_o      = valid_q;
    assign res_o        = res_q;
    assign illegal_op_o = illegal_q;

    always_comb begin
        accept    = valid_i && ready_o;
        legal     = (alu_op_i == OP_DIVU) || (alu_op_i == OP_DIVS) ||
                    (alu_op_i == OP_REMU) || (alu_op_i == OP_REMS);
        op_signed = (alu_op_i == OP_DIVS) || (alu_op_i == OP_REMS);
        op_div    = (alu_op_i == OP_DIVU) || (alu_op_i == OP_DIVS);
        a_neg     = op_signed && a_i[W-1];
        b_neg     = op_signed && b_i[W-1];
        a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
        b_mag     = b_neg ? (~b_i + 1'b1) : b_i;
        b_zero    = (b_i == '0);
        sgn_ovf   = op_signed && (a_i == MIN_NEG) && (b_i == '1);

        // Remainder stays below the divisor, so a W-bit subtract is exact.
        part      = {rem_q, quo_q[W-1]};
        ge        = (part >= {1'b0, dvs_q});

        q_fix     = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        r_fix     = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        if (bzero_q)
            final_res = is_div_q ? '1 : a_raw_q;
        else if (ovf_q)
            final_res = is_div_q ? MIN_NEG : '0;
        else
            final_res = is_div_q ? q_fix : r_fix;
    end

    always_comb begin
        state_d   = state_q;
        en_d      = 1'b1;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        ovf_d     = ovf_q;
        a_raw_d   = a_raw_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        res_d     = res_q;
        illegal_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        illegal_d = 1'b1;
                    end else begin
                        is_div_d  = op_div;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        bzero_d   = b_zero;
                        ovf_d     = sgn_ovf;
                        a_raw_d   = a_i;
                        quo_d     = a_mag;
                        rem_d     = '0;
                        dvs_d     = b_mag;
                        cnt_d     = '0;
                        state_d   = S_CALC;
`ifdef V_DIV_FAST_PATH_EN
                        if (b_zero || sgn_ovf || (a_mag < b_mag)) begin
                            quo_d   = '0;
                            rem_d   = a_mag;
                            state_d = S_DONE;
                        end
`endif
                    end
                end
            end
            S_CALC: begin
                rem_d = part[W-1:0] - (ge ? dvs_q : '0);
                quo_d = {quo_q[W-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    res_d   = final_res;
                end else if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            ovf_q     <= 1'b0;
            a_raw_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            ovf_q     <= ovf_d;
            a_raw_q   <= a_raw_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            res_q     <= res_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_v_alu_div_unit.sv
// Directed self-checking bench for v_alu_div_unit (W=32).
module tb_v_alu_div_unit;

    localparam int W = 32;
    localparam logic [4:0] DIVU = 5'b01101;
    localparam logic [4:0] DIVS = 5'b01110;
    localparam logic [4:0] REMU = 5'b01111;
    localparam logic [4:0] REMS = 5'b10000;
    localparam int LAT_FULL = 33;
`ifdef V_DIV_FAST_PATH_EN
    localparam int LAT_BYP = 1;
`else
    localparam int LAT_BYP = 33;
`endif

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [4:0]    alu_op_i = '0;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [W-1:0]  res_o;
    logic          illegal_op_o;

    int n_cmp = 0;
    int n_bad = 0;

    v_alu_div_unit #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .alu_op_i     (alu_op_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .res_o        (res_o),
        .illegal_op_o (illegal_op_o)
    );

    always #5 clk = ~clk;

    // Issues one op and waits (bounded) for valid_o; lat=-2 not accepted, -1 timeout.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        valid_i = 1'b1; alu_op_i = op; a_i = a; b_i = b;
        #1;
        if (!ready_o) begin
            valid_i = 1'b0; lat = -2; res = '0;
            return;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = res_o;
        if (!valid_o) lat = -1;
        else if (ready_i) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", valid_o); end
        n_cmp++; if (res_o !== '0) begin n_bad++; $display("FAIL rst_res got %h want 0", res_o); end
        n_cmp++; if (illegal_op_o !== 1'b0) begin n_bad++; $display("FAIL rst_illegal got %b want 0", illegal_op_o); end
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", ready_o); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after got %b want 1", ready_o); end
    endtask

    task automatic run_table(input vec_t tbl[], input string nm);
        logic [31:0] r;
        int          l;
        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, l);
            n_cmp++;
            if (r !== tbl[i].exp) begin
                n_bad++; $display("FAIL %s[%0d] res got %h want %h", nm, i, r, tbl[i].exp);
            end
            n_cmp++;
            if (l != tbl[i].lat) begin
                n_bad++; $display("FAIL %s[%0d] latency got %0d want %0d", nm, i, l, tbl[i].lat);
            end
        end
    endtask

    task automatic test_divide();
        vec_t tbl[];
        tbl = new[11];
        tbl[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         LAT_FULL};
        tbl[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          LAT_FULL};
        tbl[2]  = '{DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   LAT_FULL};
        tbl[3]  = '{DIVS, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   LAT_FULL};
        tbl[4]  = '{REMS, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   LAT_FULL};
        tbl[5]  = '{DIVS, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   LAT_FULL};
        tbl[6]  = '{REMS, 32'd7,          32'hFFFFFFFE,   32'd1,          LAT_FULL};
        tbl[7]  = '{DIVS, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         LAT_FULL};
        tbl[8]  = '{DIVU, 32'd3,          32'd10,         32'd0,          LAT_BYP};
        tbl[9]  = '{REMU, 32'd3,          32'd10,         32'd3,          LAT_BYP};
        tbl[10] = '{REMS, 32'hFFFFFFFD,   32'd10,         32'hFFFFFFFD,   LAT_BYP};
        run_table(tbl, "divide");
    endtask

    task automatic test_special();
        vec_t tbl[];
        tbl = new[7];
        tbl[0] = '{DIVS, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_BYP};
        tbl[1] = '{REMS, 32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_BYP};
        tbl[2] = '{DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_BYP};
        tbl[3] = '{REMU, 32'd5,        32'd0,        32'd5,        LAT_BYP};
        tbl[4] = '{DIVS, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, LAT_BYP};
        tbl[5] = '{REMS, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, LAT_BYP};
        tbl[6] = '{DIVS, 32'h80000000, 32'd1,        32'h80000000, LAT_FULL};
        run_table(tbl, "special");
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        int          l;
        @(negedge clk); ready_i = 1'b0;
        run_op(DIVU, 32'd100, 32'd7, r, l);
        n_cmp++; if (l != LAT_FULL) begin n_bad++; $display("FAIL bp_latency got %0d want %0d", l, LAT_FULL); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %b want 1", i, valid_o); end
            n_cmp++; if (res_o !== 32'd14) begin n_bad++; $display("FAIL bp_res[%0d] got %h want %h", i, res_o, 32'd14); end
            n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d] got %b want 0", i, ready_o); end
        end
        @(negedge clk); ready_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid got %b want 0", valid_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", ready_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int          l;
        run_op(DIVU, 32'd1000, 32'd10, r, l);
        n_cmp++; if (r !== 32'd100) begin n_bad++; $display("FAIL b2b_first got %h want %h", r, 32'd100); end
        run_op(REMU, 32'd1000, 32'd33, r, l);
        n_cmp++; if (r !== 32'd10) begin n_bad++; $display("FAIL b2b_second got %h want %h", r, 32'd10); end
        n_cmp++; if (l != LAT_FULL) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", l, LAT_FULL); end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int          l;
        int          seen;
        @(negedge clk);
        valid_i = 1'b1; alu_op_i = DIVU; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk); #1; valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); flush_i = 1'b1;
        @(posedge clk); #1; flush_i = 1'b0; #1;
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_ready got %b want 1", ready_o); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_o) seen++; end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL flush_no_valid got %0d want 0", seen); end
        // flush wins over valid_i while idle
        @(negedge clk);
        flush_i = 1'b1; valid_i = 1'b1; alu_op_i = DIVU; a_i = 32'd9; b_i = 32'd3;
        #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_prio_ready got %b want 0", ready_o); end
        @(posedge clk); #1; flush_i = 1'b0; valid_i = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_o) seen++; end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL flush_prio_no_valid got %0d want 0", seen); end
        run_op(DIVU, 32'd50, 32'd5, r, l);
        n_cmp++; if (r !== 32'd10) begin n_bad++; $display("FAIL flush_next_op got %h want %h", r, 32'd10); end
    endtask

    task automatic test_illegal();
        int seen;
        @(negedge clk);
        valid_i = 1'b1; alu_op_i = 5'b00000; a_i = 32'd1; b_i = 32'd1;
        @(posedge clk); #1; valid_i = 1'b0;
        n_cmp++; if (illegal_op_o !== 1'b1) begin n_bad++; $display("FAIL illegal_pulse got %b want 1", illegal_op_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL illegal_ready got %b want 1", ready_o); end
        @(posedge clk); #1;
        n_cmp++; if (illegal_op_o !== 1'b0) begin n_bad++; $display("FAIL illegal_pulse_end got %b want 0", illegal_op_o); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_o) seen++; end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL illegal_no_valid got %0d want 0", seen); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int          l;
        int          seen;
        @(negedge clk);
        valid_i = 1'b1; alu_op_i = DIVU; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk); #1; valid_i = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b0; #1;
        n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_calc got valid=%b ready=%b want 0/0", valid_o, ready_o);
        end
        @(negedge clk); reset = 1'b1;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_o) seen++; end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_calc_no_valid got %0d want 0", seen); end
        // reset while a result is held under backpressure
        @(negedge clk); ready_i = 1'b0;
        run_op(DIVU, 32'd9, 32'd3, r, l);
        #2 reset = 1'b0; #1;
        n_cmp++; if (valid_o !== 1'b0 || res_o !== '0) begin
            n_bad++; $display("FAIL rst_done got valid=%b res=%h want 0/0", valid_o, res_o);
        end
        @(negedge clk); reset = 1'b1; ready_i = 1'b1;
        @(posedge clk); #1;
        run_op(DIVS, 32'hFFFFFF9C, 32'd7, r, l);
        n_cmp++; if (r !== 32'hFFFFFFF2) begin n_bad++; $display("FAIL rst_post_op got %h want %h", r, 32'hFFFFFFF2); end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_special();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
